// File: rtl/audio_mute_fader_if.sv
// Sample/control bundle between the audio source side and the mute/fade gate.
// The master drives enable, mute request and samples; the slave returns scaled samples and status.
interface audio_mute_fader_if #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int RAMP_BITS = 10
);
    logic                      ce;
    logic                      mute_req;
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic [CHANNELS*WIDTH-1:0] sample_out;
    logic [RAMP_BITS:0]        gain;
    logic                      muted;
    logic                      running;

    modport master (
        output ce, mute_req, sample_in,
        input  sample_out, gain, muted, running
    );

    modport slave (
        input  ce, mute_req, sample_in,
        output sample_out, gain, muted, running
    );
endinterface

// File: rtl/audio_mute_fader.sv
// Multi-channel audio gate: silence while muted, programmable hold, then linear fade-in;
// a mute request during playback fades out before silencing.
module audio_mute_fader #(
    parameter int          CHANNELS   = 2,
    parameter int          WIDTH      = 16,
    parameter logic [23:0] HOLD_TICKS = 24'd16777215,
    parameter int          RAMP_BITS  = 10
) (
    input  logic               clk_sys,
    input  logic               reset,
    audio_mute_fader_if.slave  bus
);
    localparam int GW     = RAMP_BITS + 1;
    localparam int PW     = WIDTH + RAMP_BITS + 1;
    localparam int HOLD_W = (HOLD_TICKS > 24'd1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [GW-1:0]     FULL      = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [GW-1:0]     GAIN_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0]     GAIN_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 24'd1);

    typedef enum logic [1:0] {
        ST_MUTE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [GW-1:0]             gain_r, gain_nxt_s;
    logic [HOLD_W-1:0]         hold_cnt_r, hold_nxt_s;
    logic [CHANNELS*WIDTH-1:0] sample_out_r, scaled_s;
    logic                      muted_r, running_r;

    // Signed sample times unsigned gain, floored back to sample width; gain==FULL is identity.
    function automatic logic [WIDTH-1:0] scale_sample(input logic [WIDTH-1:0] smp,
                                                      input logic [GW-1:0]    g);
        logic signed [PW-1:0] smp_x;
        logic signed [PW-1:0] g_x;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shifted;
        smp_x   = PW'($signed(smp));
        g_x     = $signed(PW'(g));
        prod    = smp_x * g_x;
        shifted = prod >>> RAMP_BITS;
        return shifted[WIDTH-1:0];
    endfunction

    // Per-channel scaling with the gain currently held in the register.
    always_comb begin
        scaled_s = {(CHANNELS*WIDTH){1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            scaled_s[k*WIDTH +: WIDTH] = scale_sample(bus.sample_in[k*WIDTH +: WIDTH], gain_r);
        end
    end

    // Next-state, gain and hold-counter decisions for one ce tick.
    always_comb begin
        state_nxt_s = state_r;
        gain_nxt_s  = gain_r;
        hold_nxt_s  = hold_cnt_r;
        case (state_r)
            ST_MUTE: begin
                if (bus.mute_req) begin
                    hold_nxt_s = HOLD_ZERO;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_RAMP_UP;
                    gain_nxt_s  = GAIN_ZERO;
                    hold_nxt_s  = HOLD_ZERO;
                end else begin
                    hold_nxt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_RAMP_UP: begin
                // A fade-out from zero gain has nothing to ramp, so it lands in MUTE at once.
                if (bus.mute_req) begin
                    if (gain_r == GAIN_ZERO) begin
                        state_nxt_s = ST_MUTE;
                        hold_nxt_s  = HOLD_ZERO;
                    end else begin
                        state_nxt_s = ST_RAMP_DOWN;
                    end
                end else begin
                    gain_nxt_s = gain_r + GAIN_ONE;
                    if ((gain_r + GAIN_ONE) == FULL) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                    end
                end
            end
            ST_RUN: begin
                if (bus.mute_req) begin
                    state_nxt_s = ST_RAMP_DOWN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RAMP_DOWN: begin
                if (gain_r <= GAIN_ONE) begin
                    state_nxt_s = ST_MUTE;
                    gain_nxt_s  = GAIN_ZERO;
                    hold_nxt_s  = HOLD_ZERO;
                end else begin
                    gain_nxt_s = gain_r - GAIN_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_MUTE;
                gain_nxt_s  = GAIN_ZERO;
                hold_nxt_s  = HOLD_ZERO;
            end
        endcase
    end

    // State, gain, counter and output registers; everything advances only on ce.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_MUTE;
            gain_r       <= GAIN_ZERO;
            hold_cnt_r   <= HOLD_ZERO;
            sample_out_r <= {(CHANNELS*WIDTH){1'b0}};
            muted_r      <= 1'b1;
            running_r    <= 1'b0;
        end else if (bus.ce) begin
            state_r      <= state_nxt_s;
            gain_r       <= gain_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            sample_out_r <= scaled_s;
            muted_r      <= (state_nxt_s == ST_MUTE);
            running_r    <= (state_nxt_s == ST_RUN);
        end
    end

    assign bus.sample_out = sample_out_r;
    assign bus.gain       = gain_r;
    assign bus.muted      = muted_r;
    assign bus.running    = running_r;
endmodule

// File: tb/tb_audio_mute_fader.sv
// Directed bench for audio_mute_fader: a vector table walked one ce tick per row,
// followed by hand-written sequences for clock-enable stall and mid-ramp reset.
module tb_audio_mute_fader;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk_sys = ~clk_sys;

    audio_mute_fader_if #(.CHANNELS(2), .WIDTH(16), .RAMP_BITS(2)) bus ();

    audio_mute_fader #(
        .CHANNELS(2), .WIDTH(16), .HOLD_TICKS(24'd4), .RAMP_BITS(2)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic mute;
        int   s0;
        int   s1;
        int   o0;
        int   o1;
        int   g;
        int   m;
        int   r;
    } vec_t;

    vec_t tbl [35];

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input int o0, input int o1,
                             input int g, input int m, input int r);
        int a0;
        int a1;
        a0 = int'($signed(bus.sample_out[15:0]));
        a1 = int'($signed(bus.sample_out[31:16]));
        check({tag, "_out0"}, idx, a0, o0);
        check({tag, "_out1"}, idx, a1, o1);
        check({tag, "_gain"}, idx, int'(bus.gain), g);
        check({tag, "_muted"}, idx, int'(bus.muted), m);
        check({tag, "_running"}, idx, int'(bus.running), r);
    endtask

    task automatic set_in(input logic mute, input int s0, input int s1);
        bus.mute_req  = mute;
        bus.sample_in = {16'(s1), 16'(s0)};
    endtask

    // One ce pulse, then two idle clocks; called and returns at a negedge.
    task automatic ce_tick();
        bus.ce = 1'b1;
        @(negedge clk_sys);
        bus.ce = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        // power-up fade-in
        tbl[0]  = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[1]  = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[2]  = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[3]  = '{1'b0, 4096, -4096, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b0, 4096, -4096, 0, 0, 1, 0, 0};
        tbl[5]  = '{1'b0, 4096, -4096, 1024, -1024, 2, 0, 0};
        tbl[6]  = '{1'b0, 4096, -4096, 2048, -2048, 3, 0, 0};
        tbl[7]  = '{1'b0, 4096, -4096, 3072, -3072, 4, 0, 1};
        tbl[8]  = '{1'b0, 4096, -4096, 4096, -4096, 4, 0, 1};
        // fade-out from RUN
        tbl[9]  = '{1'b1, 4096, -4096, 4096, -4096, 4, 0, 0};
        tbl[10] = '{1'b0, 4096, -4096, 4096, -4096, 3, 0, 0};
        tbl[11] = '{1'b0, 4096, -4096, 3072, -3072, 2, 0, 0};
        tbl[12] = '{1'b0, 4096, -4096, 2048, -2048, 1, 0, 0};
        tbl[13] = '{1'b0, 4096, -4096, 1024, -1024, 0, 1, 0};
        tbl[14] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[15] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        // mute pulse at hold_cnt=2 restarts the hold
        tbl[16] = '{1'b1, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[17] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[18] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[19] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[20] = '{1'b0, 4096, -4096, 0, 0, 0, 0, 0};
        tbl[21] = '{1'b0, 4096, -4096, 0, 0, 1, 0, 0};
        tbl[22] = '{1'b0, 4096, -4096, 1024, -1024, 2, 0, 0};
        // mute during ramp-up at gain=2, no overshoot
        tbl[23] = '{1'b1, 4096, -4096, 2048, -2048, 2, 0, 0};
        tbl[24] = '{1'b0, 4096, -4096, 2048, -2048, 1, 0, 0};
        tbl[25] = '{1'b0, 4096, -4096, 1024, -1024, 0, 1, 0};
        tbl[26] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[27] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[28] = '{1'b0, 4096, -4096, 0, 0, 0, 1, 0};
        tbl[29] = '{1'b0, 4096, -4096, 0, 0, 0, 0, 0};
        tbl[30] = '{1'b0, 4096, -4096, 0, 0, 1, 0, 0};
        // rounding toward -inf, then full-scale extremes at FULL gain
        tbl[31] = '{1'b0, -3, 3, -1, 0, 2, 0, 0};
        tbl[32] = '{1'b0, 3, -3, 1, -2, 3, 0, 0};
        tbl[33] = '{1'b0, 1000, -1000, 750, -750, 4, 0, 1};
        tbl[34] = '{1'b0, 32767, -32768, 32767, -32768, 4, 0, 1};

        bus.ce = 1'b0;
        set_in(1'b1, 0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check_all("reset", 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 35; i++) begin
            set_in(tbl[i].mute, tbl[i].s0, tbl[i].s1);
            ce_tick();
            check_all("vec", i, tbl[i].o0, tbl[i].o1, tbl[i].g, tbl[i].m, tbl[i].r);
        end

        // ce stalled in RUN: inputs move, nothing registered may change
        set_in(1'b1, 123, -456);
        repeat (100) @(negedge clk_sys);
        check_all("noce", 0, 32767, -32768, 4, 0, 1);
        set_in(1'b0, 32767, -32768);
        ce_tick();
        check_all("noce", 1, 32767, -32768, 4, 0, 1);

        // reach RAMP_DOWN at gain=3, then reset with ce low
        set_in(1'b1, 2000, -2000);
        ce_tick();
        check_all("rstmid", 0, 2000, -2000, 4, 0, 0);
        set_in(1'b0, 2000, -2000);
        ce_tick();
        check_all("rstmid", 1, 2000, -2000, 3, 0, 0);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check_all("rstmid", 2, 0, 0, 0, 1, 0);

        // full hold again after reset before the ramp starts
        for (int t = 1; t <= 4; t++) begin
            ce_tick();
            check_all("rehold", t, 0, 0, 0, (t < 4) ? 1 : 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
